// File: rtl/mac_correlator_seq.sv
// -----------------------------------------------------------------------------
// mac_correlator_seq
//
// Sequencer and multiply-accumulate stage that sits right after the iq_demod
// sample delay line. Each accepted ADC sample is pushed into the delay line.
// Every tap is then read back one per cycle, multiplied by its coefficient
// from an external combinational ROM, and summed. The signed sum is presented
// to the despreader with a one-cycle valid pulse.
//
// Sequence per sample: IDLE -> SHIFT (1) -> ACCUM (p_depth) -> DONE (1) -> IDLE
//
// Ports
//   clk           : main clock
//   reset_n       : asynchronous active-low reset
//   sample_in     : signed 5-bit ADC sample
//   sample_valid  : 1-cycle strobe, sample_in is new
//   shift_data    : latched sample, to delay line data_in
//   shift_en      : to delay line data_shift_en (high only in SHIFT)
//   tap_index     : to delay line data_index and coefficient ROM address
//   tap_data      : delay line data_out for tap_index (same cycle)
//   coef_data     : signed coefficient for tap_index (same cycle)
//   busy          : high from the cycle after accept to the cycle after DONE
//   result        : signed correlation sum, held until the next DONE
//   result_valid  : 1-cycle pulse when result updates
//   overrun       : 1-cycle pulse when a sample arrives outside IDLE
// -----------------------------------------------------------------------------
module mac_correlator_seq #(
  parameter int p_depth      = 32,
  parameter int p_coef_width = 8,
  parameter int p_acc_width  = 5 + p_coef_width + $clog2(p_depth)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [4:0]                 sample_in,
  input  logic                       sample_valid,
  output logic [4:0]                 shift_data,
  output logic                       shift_en,
  output logic [$clog2(p_depth)-1:0] tap_index,
  input  logic [4:0]                 tap_data,
  input  logic [p_coef_width-1:0]    coef_data,
  output logic                       busy,
  output logic [p_acc_width-1:0]     result,
  output logic                       result_valid,
  output logic                       overrun
);

  localparam int idx_w  = $clog2(p_depth);
  localparam int prod_w = 5 + p_coef_width;

  localparam logic [idx_w-1:0] last_tap = idx_w'(p_depth - 1);
  localparam logic [idx_w-1:0] one_tap  = idx_w'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_reg;
  logic [4:0]               shift_data_reg;
  logic                     shift_en_reg;
  logic [idx_w-1:0]         tap_index_reg;
  logic                     busy_reg;
  logic [p_acc_width-1:0]   acc_reg;
  logic [p_acc_width-1:0]   result_reg;
  logic                     result_valid_reg;
  logic                     overrun_reg;

  // ---------------------------------------------------------------------------
  // Full-precision signed product. Both operands are sign-extended to the
  // product width first, so the low prod_w bits of the multiply are exact.
  // ---------------------------------------------------------------------------
  logic signed [prod_w-1:0] tap_ext;
  logic signed [prod_w-1:0] coef_ext;
  logic signed [prod_w-1:0] product;
  logic [p_acc_width-1:0]   product_ext;
  logic [p_acc_width-1:0]   acc_next;

  assign tap_ext  = {{p_coef_width{tap_data[4]}}, tap_data};
  assign coef_ext = {{5{coef_data[p_coef_width-1]}}, coef_data};
  assign product  = tap_ext * coef_ext;

  // Sign-extend the product up to the accumulator width bit by bit.
  genvar gi;
  generate
    for (gi = 0; gi < p_acc_width; gi++) begin : g_prod_sext
      if (gi < prod_w) begin : g_low
        assign product_ext[gi] = product[gi];
      end else begin : g_sign
        assign product_ext[gi] = product[prod_w-1];
      end
    end
  endgenerate

  // The accumulator is wide enough for p_depth worst-case products, so a
  // plain wrap-around add never actually overflows.
  assign acc_next = acc_reg + product_ext;

  // ---------------------------------------------------------------------------
  // Sequencer with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      shift_data_reg   <= '0;
      shift_en_reg     <= 1'b0;
      tap_index_reg    <= '0;
      busy_reg         <= 1'b0;
      acc_reg          <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      // A strobe outside IDLE (DONE included) is dropped and flagged; the
      // sequence in flight carries on untouched.
      overrun_reg      <= sample_valid && (state_reg != IDLE);

      case (state_reg)
        IDLE: begin
          if (sample_valid) begin
            shift_data_reg <= sample_in;
            shift_en_reg   <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= SHIFT;
          end
        end

        SHIFT: begin
          // The delay line takes the new sample at the end of this cycle,
          // so tap reads start on the following cycle.
          shift_en_reg  <= 1'b0;
          tap_index_reg <= '0;
          acc_reg       <= '0;
          state_reg     <= ACCUM;
        end

        ACCUM: begin
          acc_reg       <= acc_next;
          tap_index_reg <= tap_index_reg + one_tap;  // wraps to 0 after the last tap
          if (tap_index_reg == last_tap) begin
            state_reg <= DONE;
          end
        end

        DONE: begin
          result_reg       <= acc_reg;
          result_valid_reg <= 1'b1;
          busy_reg         <= 1'b0;
          state_reg        <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign shift_data   = shift_data_reg;
  assign shift_en     = shift_en_reg;
  assign tap_index    = tap_index_reg;
  assign busy         = busy_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_mac_correlator_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_correlator_seq
//
// Self-checking bench for mac_correlator_seq. The delay line and coefficient
// ROM around the DUT are modelled here. Expected sums come from a history of
// every sample pushed, dotted with the coefficient table.
// -----------------------------------------------------------------------------
module tb_mac_correlator_seq;

  localparam int DEPTH = 32;
  localparam int CW    = 8;
  localparam int AW    = 5 + CW + $clog2(DEPTH);
  localparam int LAT   = DEPTH + 3;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic [4:0]                 sample_in;
  logic                       sample_valid;
  logic [4:0]                 shift_data;
  logic                       shift_en;
  logic [$clog2(DEPTH)-1:0]   tap_index;
  logic [4:0]                 tap_data;
  logic [CW-1:0]              coef_data;
  logic                       busy;
  logic [AW-1:0]              result;
  logic                       result_valid;
  logic                       overrun;

  always #5 clk = ~clk;

  mac_correlator_seq #(
    .p_depth      (DEPTH),
    .p_coef_width (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .shift_data   (shift_data),
    .shift_en     (shift_en),
    .tap_index    (tap_index),
    .tap_data     (tap_data),
    .coef_data    (coef_data),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .overrun      (overrun)
  );

  // Environment: delay line (newest sample enters at the top index) and ROM.
  logic [4:0]           dl [DEPTH] = '{default: '0};
  logic signed [CW-1:0] coef_rom [DEPTH];

  always @(posedge clk) begin
    if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) dl[i] <= dl[i+1];
      dl[DEPTH-1] <= shift_data;
    end
  end

  assign tap_data  = dl[tap_index];
  assign coef_data = coef_rom[tap_index];

  // Event monitors
  int shift_cnt = 0;
  int ovr_cnt   = 0;
  int rv_cnt    = 0;
  always @(negedge clk) begin
    if (shift_en)     shift_cnt++;
    if (overrun)      ovr_cnt++;
    if (result_valid) rv_cnt++;
  end

  // Reference model: every accepted sample, oldest first.
  int hist [$];

  function automatic longint ref_dot();
    longint sum = 0;
    for (int k = 0; k < DEPTH; k++) begin
      int idx = hist.size() - 1 - (DEPTH - 1 - k);
      if (idx >= 0) sum += longint'(hist[idx]) * longint'(coef_rom[k]);
    end
    return sum;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint res_s();
    return longint'($signed(result));
  endfunction

  // Called at a negedge with the DUT idle (or returning to idle). Strobes one
  // sample, waits for result_valid and returns in that cycle, so a following
  // call strobes exactly LAT cycles after this one.
  task automatic apply(input int s, input bit use_model, input longint exp, input string name);
    int     lat  = 0;
    bit     seen = 1'b0;
    longint exp_v;
    sample_in    = 5'(s);
    sample_valid = 1'b1;
    hist.push_back(s);
    exp_v = use_model ? ref_dot() : exp;
    while (!seen && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
      sample_valid = 1'b0;
      seen = result_valid;
    end
    $display("%s: sample=%0d result=%0d expected=%0d latency=%0d", name, s, res_s(), exp_v, lat);
    check({name, " result_valid"}, longint'(seen), 1);
    check({name, " result"}, res_s(), exp_v);
    check({name, " latency"}, longint'(lat), LAT);
    check({name, " busy"}, longint'(busy), 0);
  endtask

  // Second strobe while a sequence is running, 'at' cycles after the first.
  task automatic overrun_case(input int at, input string name);
    int lat = 0;
    bit seen = 1'b0;
    int s0 = ovr_cnt;
    int sh0 = shift_cnt;
    int s = int'($urandom_range(0, 31)) - 16;
    longint exp_v;
    sample_in    = 5'(s);
    sample_valid = 1'b1;
    hist.push_back(s);
    exp_v = ref_dot();
    while (!seen && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
      sample_valid = (lat == at);
      sample_in    = 5'($urandom_range(0, 31));
      seen = result_valid;
    end
    sample_valid = 1'b0;
    @(negedge clk);
    $display("%s: result=%0d expected=%0d overruns=%0d shifts=%0d", name, res_s(), exp_v,
             ovr_cnt - s0, shift_cnt - sh0);
    check({name, " result_valid"}, longint'(seen), 1);
    check({name, " result"}, res_s(), exp_v);
    check({name, " overrun pulses"}, longint'(ovr_cnt - s0), 1);
    check({name, " shift pulses"}, longint'(shift_cnt - sh0), 1);
  endtask

  typedef struct {
    int     sample;
    longint exp_result;
  } vec_t;

  vec_t tbl [DEPTH];

  initial begin
    int sh0, ov0, rv0, lat;
    bit seen;

    for (int n = 0; n < DEPTH; n++) begin
      tbl[n].sample     = (n == 0) ? 15 : 0;
      tbl[n].exp_result = 15 * ((DEPTH - 1 - n) - 16);
    end
    for (int k = 0; k < DEPTH; k++) coef_rom[k] = CW'(k - 16);

    // 1. reset and idle
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(negedge clk);
    check("reset shift_data", longint'(shift_data), 0);
    check("reset shift_en", longint'(shift_en), 0);
    check("reset tap_index", longint'(tap_index), 0);
    check("reset busy", longint'(busy), 0);
    check("reset result", res_s(), 0);
    check("reset result_valid", longint'(result_valid), 0);
    check("reset overrun", longint'(overrun), 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("idle: shift=%0d busy=%0d tap=%0d result=%0d", shift_cnt, busy, tap_index, res_s());
    check("idle shift_en count", longint'(shift_cnt), 0);
    check("idle busy", longint'(busy), 0);
    check("idle tap_index", longint'(tap_index), 0);
    check("idle result", res_s(), 0);
    check("idle result_valid count", longint'(rv_cnt), 0);

    // 2. impulse walking the line
    for (int n = 0; n < DEPTH; n++)
      apply(tbl[n].sample, 1'b0, tbl[n].exp_result, $sformatf("impulse[%0d]", n));

    // 3. all taps -16, all coefficients -128
    for (int k = 0; k < DEPTH; k++) coef_rom[k] = -8'sd128;
    for (int n = 0; n < DEPTH - 1; n++) apply(-16, 1'b1, 0, $sformatf("fill[%0d]", n));
    apply(-16, 1'b0, 65536, "fullscale");

    // 4. overrun during ACCUM and during DONE
    for (int k = 0; k < DEPTH; k++) coef_rom[k] = CW'($urandom_range(0, 255));
    overrun_case(5, "overrun accum");
    overrun_case(LAT - 1, "overrun done");

    // 5. reset in the middle of ACCUM
    rv0 = rv_cnt;
    sample_in    = 5'd7;
    sample_valid = 1'b1;
    hist.push_back(7);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
      sample_valid = 1'b0;
      seen = busy && !shift_en && (tap_index == 10);
    end
    check("abort reached k=10", longint'(seen), 1);
    reset_n = 1'b0;
    #1;
    $display("abort: result=%0d busy=%0d rv=%0d tap=%0d", res_s(), busy, result_valid, tap_index);
    check("abort result", res_s(), 0);
    check("abort busy", longint'(busy), 0);
    check("abort result_valid", longint'(result_valid), 0);
    check("abort tap_index", longint'(tap_index), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    check("abort no result_valid", longint'(rv_cnt - rv0), 0);
    check("abort idle result", res_s(), 0);
    apply(int'($urandom_range(0, 31)) - 16, 1'b1, 0, "after abort");

    // 6. 100 back-to-back random samples
    for (int k = 0; k < DEPTH; k++) coef_rom[k] = CW'($urandom_range(0, 255));
    sh0 = shift_cnt;
    ov0 = ovr_cnt;
    for (int n = 0; n < 100; n++)
      apply(int'($urandom_range(0, 31)) - 16, 1'b1, 0, $sformatf("random[%0d]", n));
    @(negedge clk);
    check("random overrun count", longint'(ovr_cnt - ov0), 0);
    check("random shift count", longint'(shift_cnt - sh0), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
